// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I fields into instruction words and streams them into imem as
// sequential word writes, one session at a time, starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_last,
    input  logic [2:0]        i_fmt,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_imem_wren,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err,
    output logic              o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                AW1     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   L_DEPTH = AW1'(DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              r_wren;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic        w_full;
    logic        w_ready;
    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_word;
    logic        w_sext12;
    logic        w_sext13;
    logic        w_sext21;

    assign w_full   = (r_count == L_DEPTH);
    // A start pulse owns its cycle: no bundle is taken while the session resets.
    assign w_ready  = (r_state == S_LOAD) && !w_full && !i_start;
    assign w_accept = i_valid && w_ready;

    // Immediate fits when all bits above the field's sign bit replicate it.
    assign w_sext12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_sext13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_sext21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (i_fmt)
            3'd0: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            3'd1: begin
                w_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                w_legal = w_sext12;
            end
            3'd2: begin
                w_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                w_legal = w_sext12;
            end
            3'd3: begin
                w_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                w_legal = w_sext13 && !i_imm[0];
            end
            3'd4: begin
                w_word  = {i_imm[31:12], i_rd, i_opcode};
                w_legal = (i_imm[11:0] == 12'd0);
            end
            3'd5: begin
                w_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                w_legal = w_sext21 && !i_imm[0];
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= L_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_wren  <= 1'b0;
            r_waddr <= L_BASE;
            r_wdata <= '0;
        end else begin
            r_wren <= 1'b0;
            if (i_start) begin
                r_state <= S_LOAD;
                r_addr  <= L_BASE;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            // Rejected bundles still complete the handshake and can end the session.
                            if (w_legal) begin
                                r_wren  <= 1'b1;
                                r_waddr <= r_addr;
                                r_wdata <= w_word;
                                r_addr  <= r_addr + ADDR_W'(4);
                                r_count <= r_count + AW1'(1);
                            end else begin
                                r_err <= 1'b1;
                            end
                            if (i_last) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: r_state <= S_DONE;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign o_ready      = w_ready;
    assign o_imem_addr  = r_waddr;
    assign o_imem_wdata = r_wdata;
    assign o_imem_wren  = r_wren;
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_err        = r_err;
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Drives directed RV32I bundles then random sessions into instr_encoder_loader and
// compares every cycle against an arithmetic reference model of the loader.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 12;
    localparam int BASE   = 0;
    localparam int DEPTH  = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic              i_last = 1'b0;
    logic [2:0]        i_fmt = '0;
    logic [6:0]        i_opcode = '0;
    logic [2:0]        i_funct3 = '0;
    logic [6:0]        i_funct7 = '0;
    logic [4:0]        i_rd = '0;
    logic [4:0]        i_rs1 = '0;
    logic [4:0]        i_rs2 = '0;
    logic [31:0]       i_imm = '0;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_imem_wren;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_err;
    logic              o_done;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
        .o_ready(o_ready), .i_last(i_last), .i_fmt(i_fmt), .i_opcode(i_opcode),
        .i_funct3(i_funct3), .i_funct7(i_funct7), .i_rd(i_rd), .i_rs1(i_rs1),
        .i_rs2(i_rs2), .i_imm(i_imm), .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata), .o_imem_wren(o_imem_wren), .o_count(o_count),
        .o_full(o_full), .o_err(o_err), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bundle fields presented by the next cycle
    bit [2:0]  f_fmt;
    bit [31:0] f_op, f_f3, f_f7, f_rd, f_rs1, f_rs2, f_imm;

    // Reference model: session phase 0=idle 1=load 2=drain 3=done
    int        m_phase;
    int        m_count;
    bit        m_err;
    int        m_next;
    bit        m_wren;
    int        m_waddr;
    bit [31:0] m_wdata;

    function automatic bit [31:0] ref_encode(input bit [2:0] fmt, input bit [31:0] op,
            input bit [31:0] f3, input bit [31:0] f7, input bit [31:0] rd,
            input bit [31:0] rs1, input bit [31:0] rs2, input bit [31:0] imm);
        bit [31:0] base_rr;
        base_rr = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | op;
        case (fmt)
            3'd0: return (f7 << 25) | base_rr | (rd << 7);
            3'd1: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: return (((imm >> 5) & 32'h7f) << 25) | base_rr | ((imm & 32'h1f) << 7);
            3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | base_rr
                         | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
            3'd4: return (imm & 32'hfffff000) | (rd << 7) | op;
            3'd5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                         | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12)
                         | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit [2:0] fmt, input bit [31:0] imm);
        int s;
        s = int'(imm);
        case (fmt)
            3'd0: return 1'b1;
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3: return (s >= -4096) && (s <= 4095) && ((imm & 1) == 0);
            3'd4: return (imm & 32'hfff) == 0;
            3'd5: return (s >= -(1 << 20)) && (s < (1 << 20)) && ((imm & 1) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_err = 0; m_next = BASE;
        m_wren = 0; m_waddr = BASE; m_wdata = 0;
    endtask

    task automatic set_b(input bit [2:0] fmt, input bit [31:0] op, input bit [31:0] f3,
            input bit [31:0] f7, input bit [31:0] rd, input bit [31:0] rs1,
            input bit [31:0] rs2, input bit [31:0] imm);
        f_fmt = fmt; f_op = op; f_f3 = f3; f_f7 = f7;
        f_rd = rd; f_rs1 = rs1; f_rs2 = rs2; f_imm = imm;
    endtask

    task automatic check_outputs();
        chk("wren", 64'(o_imem_wren), 64'(m_wren));
        if (m_wren) begin
            chk("addr", 64'(o_imem_addr), 64'(m_waddr));
            chk("wdata", 64'(o_imem_wdata), 64'(m_wdata));
        end
        chk("count", 64'(o_count), 64'(m_count));
        chk("full", 64'(o_full), 64'(m_count == DEPTH));
        chk("err", 64'(o_err), 64'(m_err));
        chk("done", 64'(o_done), 64'(m_phase == 3));
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic cycle(input bit start, input bit valid, input bit last);
        bit exp_ready, acc;
        i_start = start; i_valid = valid; i_last = last;
        i_fmt = f_fmt; i_opcode = f_op[6:0]; i_funct3 = f_f3[2:0]; i_funct7 = f_f7[6:0];
        i_rd = f_rd[4:0]; i_rs1 = f_rs1[4:0]; i_rs2 = f_rs2[4:0]; i_imm = f_imm;
        #1;
        exp_ready = (m_phase == 1) && (m_count != DEPTH) && !start;
        chk("ready", 64'(o_ready), 64'(exp_ready));
        acc = valid && exp_ready;
        @(posedge i_clk);
        m_wren = 0;
        if (start) begin
            m_phase = 1; m_count = 0; m_err = 0; m_next = BASE;
        end else if (acc) begin
            if (ref_legal(f_fmt, f_imm)) begin
                m_wren = 1; m_waddr = m_next;
                m_wdata = ref_encode(f_fmt, f_op, f_f3, f_f7, f_rd, f_rs1, f_rs2, f_imm);
                m_next += 4; m_count++;
            end else begin
                m_err = 1;
            end
            if (last) m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end
        @(negedge i_clk);
        if (m_wren) $display("[TB] write @%03h = %08h count=%0d", m_waddr, m_wdata, m_count);
        check_outputs();
    endtask

    task automatic rand_bundle();
        bit [31:0] r;
        bit [2:0]  fmt;
        r   = $urandom;
        fmt = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        if ($urandom_range(0, 9) < 7) begin
            case (fmt)
                3'd1, 3'd2: r = {{20{r[11]}}, r[11:0]};
                3'd3: r = {{19{r[12]}}, r[12:1], 1'b0};
                3'd4: r = {r[31:12], 12'h0};
                3'd5: r = {{11{r[20]}}, r[20:1], 1'b0};
                default: r = r;
            endcase
        end
        set_b(fmt, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 127),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), r);
    endtask

    initial begin
        model_reset();
        set_b(3'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        check_outputs();
        chk("rst_addr", 64'(o_imem_addr), 64'(BASE));
        chk("rst_ready", 64'(o_ready), 64'd0);
        i_rst_n = 1'b1;

        // addi x1,x0,5
        cycle(1, 0, 0);
        set_b(3'd1, 32'h13, 0, 0, 1, 0, 0, 5);
        cycle(0, 1, 0);
        chk("addi_word", 64'(o_imem_wdata), 64'h00500093);
        chk("addi_addr", 64'(o_imem_addr), 64'h000);

        // add x3,x1,x2 then lui x5,0x12345
        cycle(1, 0, 0);
        set_b(3'd0, 32'h33, 0, 0, 3, 1, 2, 0);
        cycle(0, 1, 0);
        chk("add_word", 64'(o_imem_wdata), 64'h002081B3);
        set_b(3'd4, 32'h37, 0, 0, 5, 0, 0, 32'h12345000);
        cycle(0, 1, 0);
        chk("lui_word", 64'(o_imem_wdata), 64'h123452B7);
        chk("lui_addr", 64'(o_imem_addr), 64'h004);

        // beq x1,x2,-8 then jal x0,8 as the last instruction
        cycle(1, 0, 0);
        set_b(3'd3, 32'h63, 0, 0, 0, 1, 2, 32'hFFFFFFF8);
        cycle(0, 1, 0);
        chk("beq_word", 64'(o_imem_wdata), 64'hFE208CE3);
        set_b(3'd5, 32'h6F, 0, 0, 0, 0, 0, 8);
        cycle(0, 1, 1);
        chk("jal_word", 64'(o_imem_wdata), 64'h0080006F);
        chk("drain_done", 64'(o_done), 64'd0);
        cycle(0, 1, 0);
        chk("done_level", 64'(o_done), 64'd1);
        cycle(0, 0, 0);

        // misaligned beq is rejected, following addi lands at the base address
        cycle(1, 0, 0);
        set_b(3'd3, 32'h63, 0, 0, 0, 1, 2, 3);
        cycle(0, 1, 0);
        chk("bad_beq_err", 64'(o_err), 64'd1);
        set_b(3'd1, 32'h13, 0, 0, 1, 0, 0, 5);
        cycle(0, 1, 0);
        chk("after_bad_addr", 64'(o_imem_addr), 64'h000);
        chk("sticky_err", 64'(o_err), 64'd1);
        cycle(1, 0, 0);
        chk("start_clr_err", 64'(o_err), 64'd0);

        // fill to DEPTH, fifth bundle refused, restart at base
        for (int k = 0; k < 5; k++) begin
            set_b(3'd1, 32'h13, 0, 0, 1, 0, 0, 32'(k));
            cycle(0, 1, 0);
        end
        chk("full_flag", 64'(o_full), 64'd1);
        cycle(1, 1, 0);
        set_b(3'd1, 32'h13, 0, 0, 2, 0, 0, 7);
        cycle(0, 1, 0);
        chk("restart_addr", 64'(o_imem_addr), 64'h000);

        // async reset in the cycle after an accept drops the write at once
        cycle(0, 1, 0);
        chk("pre_rst_wren", 64'(o_imem_wren), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_wren", 64'(o_imem_wren), 64'd0);
        chk("async_count", 64'(o_count), 64'd0);
        chk("async_addr", 64'(o_imem_addr), 64'(BASE));
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle(0, 1, 0);

        // random sessions
        for (int c = 0; c < 400; c++) begin
            rand_bundle();
            cycle($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
